// File: rtl/prog_mem_pkg.sv
// Shared constants, FSM state type and address helper for the program-memory region.
// Also used by the decoder side so both agree on the index/address mapping.
package prog_mem_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h0000_18C0;
    localparam logic [31:0] LAST_ADDR = 32'h0000_1CBF;
    localparam logic [31:0] WORDS     = (LAST_ADDR - BASE_ADDR + 32'd1) >> 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } loader_state_t;

    function automatic logic [31:0] index_to_addr(input logic [31:0] idx);
        return BASE_ADDR + (idx << 2);
    endfunction

endpackage

// File: rtl/prog_word_packer.sv
// Little-endian byte-to-word assembler: byte 0 lands in bits 7:0, byte 3 in bits 31:24.
// word_full flags the accept that completes a word; word already includes that byte.
module prog_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  byte_cnt;
    logic [31:0] lanes_q;

    always_comb begin
        word = lanes_q;
        if (accept) begin
            case (byte_cnt)
                2'd0:    word[7:0]   = in_byte;
                2'd1:    word[15:8]  = in_byte;
                2'd2:    word[23:16] = in_byte;
                default: word[31:24] = in_byte;
            endcase
        end
    end

    assign word_full = accept && (byte_cnt == 2'd3);

    // Only the counter needs reset; stale lanes are always overwritten before use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= 2'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lanes_q <= word;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Byte-stream program loader: packs bytes into words and issues word-indexed writes
// carrying both the word index and the matching CPU byte address.
module prog_mem_loader
    import prog_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] load_len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_index,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    loader_state_t state, state_nxt;
    logic [31:0]   len_q;
    logic [31:0]   word_cnt;
    logic [31:0]   packed_word;
    logic          word_full;
    logic          accept;
    logic          start_ok;
    logic          last_word;

    assign accept    = in_valid && in_ready;
    assign start_ok  = (state == ST_IDLE) && start;
    assign last_word = ((word_cnt + 32'd1) == len_q);

    prog_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .accept    (accept),
        .in_byte   (in_data),
        .word      (packed_word),
        .word_full (word_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (load_len == 32'd0) begin
                        state_nxt = ST_DONE;
                    end else if (load_len <= WORDS) begin
                        state_nxt = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (word_full) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                wr_en     = 1'b1;
                state_nxt = last_word ? ST_DONE : ST_COLLECT;
            end
            default: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write outputs are captured on the completing byte so they are valid during
    // WRITE and then hold until the next word replaces them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q    <= 32'd0;
            word_cnt <= 32'd0;
            err      <= 1'b0;
            wr_index <= 32'd0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
        end else begin
            if (start_ok) begin
                err      <= (load_len > WORDS);
                len_q    <= load_len;
                word_cnt <= 32'd0;
            end
            if (word_full) begin
                wr_index <= word_cnt;
                wr_addr  <= index_to_addr(word_cnt);
                wr_data  <= packed_word;
            end
            if (state == ST_WRITE) begin
                word_cnt <= word_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed self-checking bench for prog_mem_loader with hand-computed expected writes.
module tb_prog_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_index;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    // write log filled by the monitor, read by the main sequence
    logic [31:0] log_index [0:599];
    logic [31:0] log_addr  [0:599];
    logic [31:0] log_data  [0:599];
    int          wr_count  = 0;
    int          done_count = 0;
    int          overlap   = 0;

    always #5 clk = ~clk;

    prog_mem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .load_len (load_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_count < 600) begin
                log_index[wr_count] = wr_index;
                log_addr[wr_count]  = wr_addr;
                log_data[wr_count]  = wr_data;
            end
            wr_count = wr_count + 1;
            if (in_ready === 1'b1) overlap = overlap + 1;
        end
        if (done === 1'b1) done_count = done_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and wait (bounded) for the cycle it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit toggle);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !accepted; k++) begin
            if (in_ready === 1'b1) accepted = 1'b1;
            tick();
        end
        tests++;
        assert (accepted) else begin
            fails++;
            $error("FAIL send_timeout: observed 0 expected 1 (byte %h)", b);
        end
        if (toggle) begin
            in_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        send_byte(w[7:0], toggle);
        send_byte(w[15:8], toggle);
        send_byte(w[23:16], toggle);
        send_byte(w[31:24], toggle);
    endtask

    task automatic do_start(input logic [31:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 50 && !idle; k++) begin
            if (busy === 1'b0) idle = 1'b1;
            else tick();
        end
        tests++;
        assert (idle) else begin
            fails++;
            $error("FAIL idle_timeout: observed busy=1 expected busy=0");
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
        chk({tag, "_wr_index"}, wr_index,          32'd0);
        chk({tag, "_wr_addr"},  wr_addr,           32'd0);
        chk({tag, "_wr_data"},  wr_data,           32'd0);
        chk({tag, "_busy"},     {31'd0, busy},     32'd0);
        chk({tag, "_done"},     {31'd0, done},     32'd0);
        chk({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    initial begin
        int base;
        int dbase;
        rst_n    = 1'b0;
        start    = 1'b0;
        load_len = 32'd0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // reset then idle
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk_reset_outputs("idle");
        chk("idle_no_writes", wr_count, 0);

        // two-word load, valid held high
        base  = wr_count;
        dbase = done_count;
        do_start(32'd2);
        chk("start_busy",     {31'd0, busy},     32'd1);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'h4433_2211, 1'b0);
        chk("w0_wr_en",     {31'd0, wr_en},    32'd1);
        chk("w0_in_ready",  {31'd0, in_ready}, 32'd0);
        send_word(32'h8877_6655, 1'b0);
        in_valid = 1'b0;
        chk("w1_wr_en",  {31'd0, wr_en}, 32'd1);
        chk("w1_index",  wr_index, 32'd1);
        tick();
        chk("done_pulse",   {31'd0, done},  32'd1);
        chk("done_busy",    {31'd0, busy},  32'd1);
        chk("done_wr_en",   {31'd0, wr_en}, 32'd0);
        chk("hold_data",    wr_data, 32'h8877_6655);
        chk("hold_addr",    wr_addr, 32'h0000_18C4);
        tick();
        chk("after_busy",   {31'd0, busy}, 32'd0);
        chk("after_done",   {31'd0, done}, 32'd0);
        chk("l2_count",     wr_count - base, 2);
        chk("l2_done_cnt",  done_count - dbase, 1);
        chk("l2_idx0",  log_index[base],     32'd0);
        chk("l2_addr0", log_addr[base],      32'h0000_18C0);
        chk("l2_data0", log_data[base],      32'h4433_2211);
        chk("l2_idx1",  log_index[base + 1], 32'd1);
        chk("l2_addr1", log_addr[base + 1],  32'h0000_18C4);
        chk("l2_data1", log_data[base + 1],  32'h8877_6655);

        // same load with in_valid toggling
        base  = wr_count;
        dbase = done_count;
        do_start(32'd2);
        send_word(32'h4433_2211, 1'b1);
        send_word(32'h8877_6655, 1'b1);
        wait_idle();
        chk("tg_count",    wr_count - base, 2);
        chk("tg_done_cnt", done_count - dbase, 1);
        chk("tg_data0",    log_data[base],     32'h4433_2211);
        chk("tg_addr0",    log_addr[base],     32'h0000_18C0);
        chk("tg_data1",    log_data[base + 1], 32'h8877_6655);
        chk("tg_idx1",     log_index[base + 1], 32'd1);
        chk("no_overlap",  overlap, 0);

        // full-capacity load
        base = wr_count;
        do_start(32'd256);
        for (int i = 0; i < 256; i++) begin
            send_word(32'hC0DE_0000 + 32'(i), 1'b0);
        end
        in_valid = 1'b0;
        wait_idle();
        chk("full_count",  wr_count - base, 256);
        chk("full_first_addr", log_addr[base], 32'h0000_18C0);
        chk("full_mid_data",   log_data[base + 128], 32'hC0DE_0080);
        chk("full_mid_addr",   log_addr[base + 128], 32'h0000_1AC0);
        chk("full_last_idx",   log_index[base + 255], 32'd255);
        chk("full_last_addr",  log_addr[base + 255], 32'h0000_1CBC);
        chk("full_last_data",  log_data[base + 255], 32'hC0DE_00FF);

        // oversize load rejected
        base = wr_count;
        do_start(32'd257);
        chk("over_err",      {31'd0, err},      32'd1);
        chk("over_busy",     {31'd0, busy},     32'd0);
        chk("over_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (5) tick();
        chk("over_err_sticky", {31'd0, err},  32'd1);
        chk("over_busy_late",  {31'd0, busy}, 32'd0);
        chk("over_no_writes",  wr_count - base, 0);

        // zero-length load
        base = wr_count;
        do_start(32'd0);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd1);
        chk("zero_err_cleared", {31'd0, err}, 32'd0);
        tick();
        chk("zero_done_low", {31'd0, done}, 32'd0);
        chk("zero_busy_low", {31'd0, busy}, 32'd0);
        chk("zero_no_writes", wr_count - base, 0);

        // start during a load is ignored
        base = wr_count;
        do_start(32'd1);
        send_byte(8'hA1, 1'b0);
        send_byte(8'hB2, 1'b0);
        in_valid = 1'b0;
        do_start(32'd5);
        send_byte(8'hC3, 1'b0);
        send_byte(8'hD4, 1'b0);
        in_valid = 1'b0;
        wait_idle();
        chk("mid_start_count", wr_count - base, 1);
        chk("mid_start_data",  log_data[base], 32'hD4C3_B2A1);
        chk("mid_start_idx",   log_index[base], 32'd0);

        // reset in the middle of word 1, with start held across reset
        base = wr_count;
        do_start(32'd3);
        send_word(32'hDDCC_BBAA, 1'b0);
        send_byte(8'hEE, 1'b0);
        send_byte(8'hFF, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b1;
        load_len = 32'd1;
        tick();
        start    = 1'b0;
        chk_reset_outputs("rst_mid");
        rst_n = 1'b1;
        tick();
        chk("rst_start_ignored", {31'd0, busy}, 32'd0);
        chk("rst_written", wr_count - base, 1);
        do_start(32'd1);
        send_word(32'h0403_0201, 1'b0);
        in_valid = 1'b0;
        chk("fresh_idx",  wr_index, 32'd0);
        chk("fresh_addr", wr_addr,  32'h0000_18C0);
        chk("fresh_data", wr_data,  32'h0403_0201);
        wait_idle();
        chk("fresh_count", wr_count - base, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
